// File: rtl/shade_stream_packer_if.sv
// Stream interfaces for shade_stream_packer: 24-bit pixel input and 32-bit AXI4-Stream video output.
interface pix_stream_if;
  logic [23:0] pix_rgb;
  logic        pix_valid;
  logic        pix_ready;

  modport master (output pix_rgb, output pix_valid, input  pix_ready);
  modport slave  (input  pix_rgb, input  pix_valid, output pix_ready);
endinterface

interface axis_video_if;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;

  modport master (output m_tdata, output m_tvalid, output m_tlast, output m_tuser, input m_tready);
  modport slave  (input  m_tdata, input  m_tvalid, input  m_tlast, input  m_tuser, output m_tready);
endinterface

// File: rtl/shade_stream_packer.sv
// Packs four 24-bit shades into three 32-bit AXI4-Stream video words with tuser/tlast framing.
// Optional macro SHADE_PACKER_BGR_EN reorders each pixel to {b,g,r} before packing.
module shade_stream_packer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic         aclk,
  input  logic         aresetn,
  pix_stream_if.slave  pix,
  axis_video_if.master m_axis,
  input  logic         frame_restart,
  output logic         frame_done
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST  = XW'(H_RES - 1);
  localparam logic [XW-1:0] X_FIRST = XW'(1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_RES - 1);

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

  phase_t        phase;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [23:0]   res;

  logic [23:0]   pix_p0;
  logic          ready_p0;
  logic          accept_p0;

  logic [31:0]   tdata_p1;
  logic          vld_p1;
  logic          tlast_p1;
  logic          tuser_p1;
  logic          flast_p1;

`ifdef SHADE_PACKER_BGR_EN
  function automatic logic [23:0] bgr_swap(input logic [23:0] p);
    return {p[7:0], p[15:8], p[23:16]};
  endfunction
`endif

  // Word built from the incoming pixel and the bytes still held from earlier pixels.
  function automatic logic [31:0] pack_word(input logic [1:0] ph, input logic [23:0] p,
                                            input logic [23:0] r);
    logic [31:0] w;
    case (ph)
      2'd1:    w = {p[7:0],  r[23:0]};
      2'd2:    w = {p[15:0], r[15:0]};
      default: w = {p[23:0], r[7:0]};
    endcase
    return w;
  endfunction

  function automatic logic [23:0] next_residue(input logic [1:0] ph, input logic [23:0] p);
    logic [23:0] r;
    case (ph)
      2'd0:    r = p;
      2'd1:    r = {8'h00,  p[23:8]};
      2'd2:    r = {16'h0000, p[23:16]};
      default: r = 24'h000000;
    endcase
    return r;
  endfunction

  // ---- stage p0: pixel intake ----
`ifdef SHADE_PACKER_BGR_EN
  assign pix_p0 = bgr_swap(pix.pix_rgb);
`else
  assign pix_p0 = pix.pix_rgb;
`endif

  // Phase 0 never emits, so it can always take a pixel even while the slot is stalled.
  assign ready_p0  = ~frame_restart & ((phase == PH0) | ~vld_p1 | m_axis.m_tready);
  assign accept_p0 = pix.pix_valid & ready_p0;
  assign pix.pix_ready = ready_p0;

  // ---- stage p1: output word slot ----
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase      <= PH0;
      x          <= '0;
      y          <= '0;
      res        <= '0;
      tdata_p1   <= '0;
      vld_p1     <= 1'b0;
      tlast_p1   <= 1'b0;
      tuser_p1   <= 1'b0;
      flast_p1   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= vld_p1 & m_axis.m_tready & tlast_p1 & flast_p1;

      if (vld_p1 & m_axis.m_tready)
        vld_p1 <= 1'b0;

      if (frame_restart) begin
        phase <= PH0;
        x     <= '0;
        y     <= '0;
        res   <= '0;
      end else if (accept_p0) begin
        if (phase != PH0) begin
          vld_p1   <= 1'b1;
          tdata_p1 <= pack_word(phase, pix_p0, res);
          tlast_p1 <= (x == X_LAST);
          tuser_p1 <= (x == X_FIRST) && (y == '0);
          flast_p1 <= (y == Y_LAST);
        end
        res <= next_residue(phase, pix_p0);

        case (phase)
          PH0:     phase <= PH1;
          PH1:     phase <= PH2;
          PH2:     phase <= PH3;
          default: phase <= PH0;
        endcase

        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  assign m_axis.m_tdata  = tdata_p1;
  assign m_axis.m_tvalid = vld_p1;
  assign m_axis.m_tlast  = tlast_p1;
  assign m_axis.m_tuser  = tuser_p1;

endmodule

// File: doc/shade_stream_packer.md
Name: shade_stream_packer

Overview:
- Sits downstream of the per-pixel shader and receives one packed 24-bit RGB shade per accepted pixel, in {r,g,b} order (r in [23:16]).
- Packs four 24-bit pixels into three 32-bit words and drives them onto an AXI4-Stream video master towards the VDMA/display path.
- Tracks raster position to generate tuser (start of frame) and tlast (end of line).

Parameters:
- H_RES, 640, pixels per line; must be a multiple of 4 and at least 4.
- V_RES, 480, lines per frame; at least 1.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- pix_rgb  in  24  shade value {r,g,b}
- pix_valid  in  1  pix_rgb valid
- pix_ready  out  1  packer accepts pix_rgb this cycle
- frame_restart  in  1  sync pulse: abandon partial frame, next pixel is (0,0)
- m_tdata  out  32  packed stream word
- m_tvalid  out  1  stream word valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  last word of a line
- m_tuser  out  1  first word of a frame
- frame_done  out  1  one-cycle pulse when last word of frame is accepted

Behaviour:
- One clock (aclk). Reset is asynchronous and active-low (aresetn).
- Reset values:
  - m_tvalid=0, m_tdata=0, m_tlast=0, m_tuser=0, frame_done=0.
  - phase=0, x=0, y=0, residue=0.
  - pix_ready=1 after reset, since phase=0.
- Pixel accept = pix_valid & pix_ready. x/y advance only on accept.
- x wraps H_RES-1 -> 0, and y increments on that wrap. y wraps V_RES-1 -> 0.
- Phase state machine, 2-bit, advancing 0->1->2->3->0 on each accept. p0..p3 are the accepted pixels of a group and res is the residue register.
  - P0: res <= p0. No word is produced.
  - P1: emit {p1[7:0], res[23:0]}; res <= p1[23:8].
  - P2: emit {p2[15:0], res[15:0]}; res <= p2[23:16].
  - P3: emit {p3[23:0], res[7:0]}; res <= 0.
- Output is a single registered word slot.
  - "Emit" loads m_tdata/m_tlast/m_tuser and sets m_tvalid the cycle after the accept. Latency is 1 cycle.
  - pix_ready = (phase==0) | ~m_tvalid | m_tready. Accept and emit may coincide with the slot draining, which gives full throughput of 1 pixel/cycle.
  - m_tvalid stays 1 and m_tdata/m_tlast/m_tuser stay stable until m_tvalid & m_tready. AXI rule: no dropping and no change while stalled.
- m_tuser=1 only on the word emitted by phase 1 of pixel (x=1,y=0), i.e. the first word of the frame.
- m_tlast=1 only on the word emitted by the accept of x=H_RES-1, which is always phase 3 because H_RES%4==0.
- frame_done=1 for exactly one cycle when a word with m_tlast=1 is accepted downstream while its line is y=V_RES-1.
  - Track this with a registered flag latched at emit time.
- frame_restart has priority over a pixel accept in the same cycle.
  - It sets phase=0, x=0, y=0 and res=0.
  - pix_ready is forced to 0 during that cycle.
  - A pending output word stays valid and is delivered unchanged; it is not flushed.
- aresetn asserted mid-frame: everything returns to reset values immediately. Any pending word is lost.
- Backpressure boundary: with m_tvalid=1 and m_tready=0, pix_ready=1 only in phase 0. The P0 accept proceeds, and the next pixel waits.
- No internal FIFO beyond the residue register and the one word slot.

Optional Feature:
- Macro: SHADE_PACKER_BGR_EN.
- Defined: each accepted pixel is reordered to {b,g,r} (pix_rgb[7:0] to bits [23:16], pix_rgb[23:16] to bits [7:0]) before packing. Framing and timing are identical.
- Undefined: pixels are packed exactly as received ({r,g,b}).

Test Plan:
- Bench uses H_RES=8, V_RES=2, m_tready=1. Pixels 0x112233, 0x445566, 0x778899, 0xAABBCC -> words 0x66112233 (tuser=1), 0x88994455, 0xAABBCC77 (tlast=0), each 1 cycle after the completing accept.
- Full frame of 16 pixels, values 0..15 -> 12 words; m_tlast on words 6 and 12, m_tuser on word 1 only, one frame_done pulse after word 12. A second frame repeats the tuser on its first word.
- m_tready=0 for 5 cycles while pixels stream -> m_tdata held stable; pix_ready low except in phase 0; no word lost or duplicated against the reference packing model.
- Assert frame_restart after 2 pixels with the word 0x66112233 pending -> that word is still delivered; the next pixel is treated as (0,0) and the next word has m_tuser=1.
- aresetn low mid-line with m_tvalid=1 -> m_tvalid=0 asynchronously. After release, the first 4 pixels produce a tuser word.
- With SHADE_PACKER_BGR_EN defined, pixel 0x112233 -> first word low 24 bits = 0x332211.
